// File: rtl/mmio_uart_ctrl.sv
// mmio_uart_ctrl: memory-mapped UART controller for the 0x8xxx_xxxx region.
// It holds RX and TX byte FIFOs between the CPU and the UART, plus cycle and
// retired-instruction counters that software can clear. Load data is
// registered and appears one cycle after the request.
// Optional build macro MMIO_UART_IRQ_EN adds the IRQ_EN register at 0x1C
// and drives irq from it. When the macro is not defined, irq is tied low.
module mmio_uart_ctrl #(
  parameter int RX_DEPTH = 8,
  parameter int TX_DEPTH = 8,
  parameter int CNT_W    = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] req_addr,
  input  logic        req_load,
  input  logic        req_store,
  input  logic [3:0]  req_wmask,
  input  logic [31:0] req_wdata,
  output logic [31:0] rdata,
  input  logic        inst_retire,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        irq
);

  localparam int RX_AW = $clog2(RX_DEPTH);
  localparam int TX_AW = $clog2(TX_DEPTH);

  logic             sel, ld, st;
  logic [7:0]       off;

  logic [7:0]       rx_mem [RX_DEPTH];
  logic [RX_AW-1:0] rx_wptr, rx_rptr;
  logic [RX_AW:0]   rx_count;
  logic             rx_full, rx_empty, rx_push, rx_pop;

  logic [7:0]       tx_mem [TX_DEPTH];
  logic [TX_AW-1:0] tx_wptr, tx_rptr;
  logic [TX_AW:0]   tx_count;
  logic             tx_full, tx_empty, tx_wr, tx_push, tx_pop;
  logic             tx_ovf, ovf_clr;

  logic [CNT_W-1:0] cyc_cnt, ins_cnt;
  logic             cnt_clr;

  logic [31:0]      status, cyc_ext, ins_ext, rd_val;
  logic [7:0]       rx_cnt8, tx_cnt8;

  logic             unused_ok;
  assign unused_ok = ^{req_addr[27:8], req_wdata[31:8]};

  // Decode. A load wins over a store in the same cycle, and a store with an
  // all-zero byte mask is not a store.
  always_comb begin
    sel = (req_addr[31:28] == 4'h8);
    off = req_addr[7:0];
    ld  = req_load & sel;
    st  = req_store & sel & (|req_wmask) & ~req_load;
  end

  // FIFO handshakes. rx_ready drops at full even when a pop is pending.
  always_comb begin
    rx_full  = (rx_count == (RX_AW+1)'(RX_DEPTH));
    rx_empty = (rx_count == '0);
    rx_ready = ~rx_full;
    rx_push  = rx_valid & ~rx_full;
    rx_pop   = ld & (off == 8'h04) & ~rx_empty;

    tx_full  = (tx_count == (TX_AW+1)'(TX_DEPTH));
    tx_empty = (tx_count == '0);
    tx_valid = ~tx_empty;
    tx_data  = tx_mem[tx_rptr];
    tx_wr    = st & (off == 8'h08);
    tx_push  = tx_wr & ~tx_full;
    tx_pop   = ~tx_empty & tx_ready;

    ovf_clr  = st & (off == 8'h00) & req_wdata[2];
    cnt_clr  = st & (off == 8'h18);
  end

  // RX storage. Reset does not clear it; the pointers discard its contents.
  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wptr] <= rx_data;
  end

  // RX pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_wptr  <= '0;
      rx_rptr  <= '0;
      rx_count <= '0;
    end else begin
      if (rx_push) rx_wptr <= rx_wptr + 1'b1;
      if (rx_pop)  rx_rptr <= rx_rptr + 1'b1;
      if (rx_push && !rx_pop)      rx_count <= rx_count + 1'b1;
      else if (!rx_push && rx_pop) rx_count <= rx_count - 1'b1;
    end
  end

  // TX storage
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wptr] <= req_wdata[7:0];
  end

  // TX pointers, occupancy, and the sticky overflow flag. A store that finds
  // the FIFO full is dropped, even if a byte drains in that same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_wptr  <= '0;
      tx_rptr  <= '0;
      tx_count <= '0;
      tx_ovf   <= 1'b0;
    end else begin
      if (tx_push) tx_wptr <= tx_wptr + 1'b1;
      if (tx_pop)  tx_rptr <= tx_rptr + 1'b1;
      if (tx_push && !tx_pop)      tx_count <= tx_count + 1'b1;
      else if (!tx_push && tx_pop) tx_count <= tx_count - 1'b1;
      if (tx_wr && tx_full) tx_ovf <= 1'b1;
      else if (ovf_clr)     tx_ovf <= 1'b0;
    end
  end

  // Free-running counters. A clear takes priority over an increment in the
  // same cycle.
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      cyc_cnt <= '0;
      ins_cnt <= '0;
    end else begin
      cyc_cnt <= cyc_cnt + 1'b1;
      if (inst_retire) ins_cnt <= ins_cnt + 1'b1;
    end
  end

`ifdef MMIO_UART_IRQ_EN
  logic [1:0] irq_en;

  // Interrupt enable register, and irq registered one cycle behind the state
  always_ff @(posedge clk) begin
    if (rst) begin
      irq_en <= 2'b00;
      irq    <= 1'b0;
    end else begin
      if (st && off == 8'h1C) irq_en <= req_wdata[1:0];
      irq <= (irq_en[0] & ~rx_empty) | (irq_en[1] & tx_empty);
    end
  end
`else
  assign irq = 1'b0;
`endif

  // Read mux. It uses the state at request time, before any pop or push.
  always_comb begin
    rx_cnt8 = '0;
    rx_cnt8[RX_AW:0] = rx_count;
    tx_cnt8 = '0;
    tx_cnt8[TX_AW:0] = tx_count;
    cyc_ext = '0;
    cyc_ext[CNT_W-1:0] = cyc_cnt;
    ins_ext = '0;
    ins_ext[CNT_W-1:0] = ins_cnt;
    status = {8'h00, tx_cnt8, rx_cnt8, 5'b0, tx_ovf, ~rx_empty, ~tx_full};
    rd_val = '0;
    case (off)
      8'h00: rd_val = status;
      8'h04: rd_val = rx_empty ? 32'h0 : {24'h0, rx_mem[rx_rptr]};
      8'h10: rd_val = cyc_ext;
      8'h14: rd_val = ins_ext;
`ifdef MMIO_UART_IRQ_EN
      8'h1C: rd_val = {30'h0, irq_en};
`endif
      default: rd_val = '0;
    endcase
  end

  // Registered load data. It is zero in any cycle that follows a non-load.
  always_ff @(posedge clk) begin
    if (rst)     rdata <= '0;
    else if (ld) rdata <= rd_val;
    else         rdata <= '0;
  end

endmodule

// File: tb/tb_mmio_uart_ctrl.sv
// tb_mmio_uart_ctrl: scoreboard bench for mmio_uart_ctrl.
// A second instance with CNT_W=4 shares all inputs, so counter wrap can be
// observed on it.
module tb_mmio_uart_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] req_addr;
  logic        req_load, req_store;
  logic [3:0]  req_wmask;
  logic [31:0] req_wdata;
  logic        inst_retire;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;

  logic [31:0] rdata, rdata4;
  logic [7:0]  tx_data, tx_data4;
  logic        tx_valid, tx_valid4, rx_ready, rx_ready4, irq, irq4;

`ifdef MMIO_UART_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif

  always #5 clk = ~clk;

  mmio_uart_ctrl #(.RX_DEPTH(8), .TX_DEPTH(8), .CNT_W(32)) u_dut (
    .clk(clk), .rst(rst), .req_addr(req_addr), .req_load(req_load),
    .req_store(req_store), .req_wmask(req_wmask), .req_wdata(req_wdata),
    .rdata(rdata), .inst_retire(inst_retire), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .rx_data(rx_data),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .irq(irq)
  );

  mmio_uart_ctrl #(.RX_DEPTH(8), .TX_DEPTH(8), .CNT_W(4)) u_dut4 (
    .clk(clk), .rst(rst), .req_addr(req_addr), .req_load(req_load),
    .req_store(req_store), .req_wmask(req_wmask), .req_wdata(req_wdata),
    .rdata(rdata4), .inst_retire(inst_retire), .tx_data(tx_data4),
    .tx_valid(tx_valid4), .tx_ready(tx_ready), .rx_data(rx_data),
    .rx_valid(rx_valid), .rx_ready(rx_ready4), .irq(irq4)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] exp;
    logic [31:0] exp4;
    bit          chk4;
  } ld_exp_t;

  ld_exp_t    rq[$];
  logic [7:0] txq[$];
  int n_tests = 0;
  int n_fail  = 0;

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic load(input logic [31:0] a, input logic [31:0] e);
    ld_exp_t x;
    x = '{a, e, 32'h0, 1'b0};
    req_addr = a;
    req_load = 1'b1;
    rq.push_back(x);
    tick();
    req_load = 1'b0;
  endtask

  task automatic load2(input logic [31:0] a, input logic [31:0] e,
                       input logic [31:0] e4);
    ld_exp_t x;
    x = '{a, e, e4, 1'b1};
    req_addr = a;
    req_load = 1'b1;
    rq.push_back(x);
    tick();
    req_load = 1'b0;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] m);
    req_addr  = a;
    req_store = 1'b1;
    req_wdata = d;
    req_wmask = m;
    tick();
    req_store = 1'b0;
    req_wmask = 4'h0;
  endtask

  // Load-data monitor. When a load was presented in a cycle, it checks rdata
  // one cycle later against the queued expectation. Otherwise rdata must be 0.
  initial begin : mon_rd
    bit pend;
    ld_exp_t e;
    pend = 1'b0;
    forever begin
      @(negedge clk);
      if (pend) begin
        if (rq.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL rdata_unexpected: got 0x%08h, expected no load result", rdata);
        end else begin
          e = rq.pop_front();
          check($sformatf("rdata@%08h", e.addr), rdata, e.exp);
          if (e.chk4) check($sformatf("rdata4@%08h", e.addr), rdata4, e.exp4);
        end
      end else begin
        check("rdata_idle", rdata, 32'h0);
      end
      pend = req_load;
    end
  end

  // TX monitor: every handshake must carry the next expected byte
  initial begin : mon_tx
    forever begin
      @(negedge clk);
      if (tx_valid && tx_ready) begin
        if (txq.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL tx_unexpected: got 0x%02h, expected no byte", tx_data);
        end else begin
          check("tx_data", {24'h0, tx_data}, {24'h0, txq.pop_front()});
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

  initial begin : stim
    rst = 1'b1; req_addr = '0; req_load = 0; req_store = 0; req_wmask = '0;
    req_wdata = '0; inst_retire = 0; tx_ready = 0; rx_data = '0; rx_valid = 0;
    idle(2);
    rst = 1'b0;
    check("reset_tx_valid", {31'h0, tx_valid}, 32'h0);
    check("reset_rx_ready", {31'h0, rx_ready}, 32'h1);
    check("reset_irq", {31'h0, irq}, 32'h0);

    // Status after reset
    load(32'h8000_0000, 32'h0000_0001);

    // RX bytes come out in order. A pop from an empty FIFO returns 0.
    rx_valid = 1'b1;
    rx_data = 8'h41; tick();
    rx_data = 8'h42; tick();
    rx_data = 8'h43; tick();
    rx_valid = 1'b0;
    load(32'h8000_0000, 32'h0000_0303);
    load(32'h8000_0004, 32'h41);
    load(32'h8000_0004, 32'h42);
    load(32'h8000_0004, 32'h43);
    load(32'h8000_0004, 32'h0);
    load(32'h8000_0000, 32'h0000_0001);

    // Unselected and unmapped loads return 0
    load(32'h8000_0020, 32'h0);
    load(32'h0000_0000, 32'h0);
    load(32'h9000_0000, 32'h0);

    // TX overflow. The byte 0x18 and a store made while draining at full
    // are both dropped.
    for (int i = 0; i < 9; i++) store(32'h8000_0008, 32'h10 + i, 4'hF);
    load(32'h8000_0000, 32'h0008_0004);
    store(32'h8000_0000, 32'h4, 4'hF);
    load(32'h8000_0000, 32'h0008_0000);
    check("tx_valid_full", {31'h0, tx_valid}, 32'h1);
    check("tx_head", {24'h0, tx_data}, 32'h10);
    for (int i = 0; i < 8; i++) txq.push_back(8'(8'h10 + i));
    tx_ready = 1'b1;
    store(32'h8000_0008, 32'h20, 4'hF);
    idle(7);
    tx_ready = 1'b0;
    check("tx_drained", {31'h0, tx_valid}, 32'h0);
    load(32'h8000_0000, 32'h0000_0005);
    store(32'h8000_0000, 32'h4, 4'hF);
    load(32'h8000_0000, 32'h0000_0001);

    // Stores with a zero mask, unselected stores, and stores that collide
    // with a load must not push
    store(32'h8000_0008, 32'h55, 4'h0);
    store(32'h0000_0008, 32'h56, 4'hF);
    req_store = 1'b1; req_wdata = 32'h5A; req_wmask = 4'hF;
    load(32'h8000_0008, 32'h0);
    req_store = 1'b0; req_wmask = 4'h0;
    check("tx_no_push", {31'h0, tx_valid}, 32'h0);

    // A push into an empty TX FIFO is visible on tx_valid the next cycle
    req_addr = 32'h8000_0008; req_store = 1'b1; req_wdata = 32'h99; req_wmask = 4'h1;
    check("tx_valid_same_cycle", {31'h0, tx_valid}, 32'h0);
    tick();
    req_store = 1'b0; req_wmask = 4'h0;
    check("tx_valid_next", {31'h0, tx_valid}, 32'h1);
    check("tx_data_next", {24'h0, tx_data}, 32'h99);
    txq.push_back(8'h99);
    tx_ready = 1'b1; tick(); tx_ready = 1'b0;
    check("tx_empty_again", {31'h0, tx_valid}, 32'h0);

    // RX at full: a pop does not reopen rx_ready in the same cycle
    rx_valid = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      rx_data = 8'(i);
      tick();
    end
    rx_data = 8'h09;
    check("rx_ready_full", {31'h0, rx_ready}, 32'h0);
    load(32'h8000_0004, 32'h01);
    check("rx_ready_after_pop", {31'h0, rx_ready}, 32'h1);
    tick();
    rx_valid = 1'b0;
    load(32'h8000_0000, 32'h0000_0803);
    for (int i = 2; i <= 9; i++) load(32'h8000_0004, 32'(i));

    // A simultaneous push and pop leaves the occupancy unchanged
    rx_valid = 1'b1; rx_data = 8'hA0; tick();
    rx_data = 8'hA1;
    load(32'h8000_0004, 32'hA0);
    rx_valid = 1'b0;
    load(32'h8000_0000, 32'h0000_0103);
    load(32'h8000_0004, 32'hA1);
    load(32'h8000_0004, 32'h0);

    // Counters. The CNT_W=4 instance reads its value modulo 16.
    store(32'h8000_0018, 32'h0, 4'hF);
    for (int i = 0; i < 20; i++) begin
      inst_retire = (i % 4 == 0);
      tick();
    end
    inst_retire = 1'b0;
    load2(32'h8000_0014, 32'd5, 32'd5);
    load2(32'h8000_0010, 32'd21, 32'd5);
    inst_retire = 1'b1;
    store(32'h8000_0018, 32'h1, 4'h1);
    inst_retire = 1'b0;
    load2(32'h8000_0014, 32'd0, 32'd0);
    load2(32'h8000_0010, 32'd1, 32'd1);
    store(32'h8000_0018, 32'h0, 4'hF);
    idle(16);
    load2(32'h8000_0010, 32'd16, 32'd0);

    // Reset mid-operation clears the FIFOs and kills the in-flight rdata
    store(32'h8000_0008, 32'h31, 4'hF);
    store(32'h8000_0008, 32'h32, 4'hF);
    rx_valid = 1'b1; rx_data = 8'h77; tick(); rx_valid = 1'b0;
    load(32'h8000_0000, 32'h0002_0103);
    rst = 1'b1;
    load(32'h8000_0000, 32'h0);
    rst = 1'b0;
    check("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
    check("rst_rx_ready", {31'h0, rx_ready}, 32'h1);
    load(32'h8000_0000, 32'h0000_0001);

    // Interrupt: follows rx_not_empty one cycle late when enabled, or stays
    // 0 in the default build
    store(32'h8000_001C, 32'h1, 4'hF);
    load(32'h8000_001C, IRQ_ON ? 32'h1 : 32'h0);
    rx_valid = 1'b1; rx_data = 8'h5E; tick(); rx_valid = 1'b0;
    check("irq_lag", {31'h0, irq}, 32'h0);
    tick();
    check("irq_set", {31'h0, irq}, IRQ_ON ? 32'h1 : 32'h0);
    load(32'h8000_0004, 32'h5E);
    check("irq_hold", {31'h0, irq}, IRQ_ON ? 32'h1 : 32'h0);
    tick();
    check("irq_clear", {31'h0, irq}, 32'h0);

    idle(3);
    check("rd_queue_drain", 32'(rq.size()), 32'h0);
    check("tx_queue_drain", 32'(txq.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
